// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and default widths for the data memory and cpu
package mem_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 8;
    localparam int LATENCY_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - storage array with sync write, registered read and clear-all
module dmem_array #(
    parameter  int ADDR_W = 8,
    parameter  int DATA_W = 8,
    localparam int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Next contents: one location written on a write commit, read register loaded on a read commit
    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (we) begin
            mem_d[addr] = wdata;
        end
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    // Clear wipes every location and the read register, overriding any commit in that cycle
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - multi-cycle data memory with BUSYWAIT stall handshake
module data_memory
    import mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WRITEDATA,
    output logic [DATA_W-1:0] READDATA,
    output logic              BUSYWAIT
);

    // Counter is loaded so that the commit lands exactly LATENCY edges after acceptance
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              commit;
    logic              valid_req;

    // Asserting both READ and WRITE is treated as no request at all
    assign valid_req = READ ^ WRITE;

    // Stall rises combinationally with a fresh request and holds while the access is in flight
    assign BUSYWAIT = ((state_q == ST_IDLE) && valid_req) || (state_q == ST_BUSY);

    // Next-state: accept in IDLE, count down in BUSY, one quiet DONE cycle before re-arming
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_req) begin
                    op_d    = WRITE ? OP_WRITE : OP_READ;
                    addr_d  = ADDRESS;
                    data_d  = WRITEDATA;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any access in flight
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (CLK),
        .clr   (RESET),
        .we    (commit && (op_q == OP_WRITE)),
        .re    (commit && (op_q == OP_READ)),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (READDATA)
    );

endmodule
